// File: rtl/mc_cpu_if.sv
// mc_cpu_if: unified memory port shared by instruction fetch and load/store.
//   master (CPU)    : drives req, we, addr, wdata; receives rdata, ack
//   slave  (memory) : receives req, we, addr, wdata; drives rdata, ack
// A request completes in the cycle ack is high while req is high; ack may
// arrive in the same cycle req first rises.
interface mc_cpu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core, one FSM state per phase, single
// shared memory port (mc_cpu_if.master) for fetch and load/store.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   mem         memory bus (req/we/addr/wdata out, rdata/ack in)
//   halted      high while in HALT (entered on fetching 32'hFFFF_FFFF)
//   retire      high in the last cycle of each instruction
//   retire_pc   PC of the retiring instruction
//   write_data  value written to the register file (valid with retire)
// Optional feature: define MC_CPU_BNE_EN to decode opcode 0x05 as bne;
// otherwise 0x05 executes as a NOP.
module mc_cpu #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       REG_AW   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    mc_cpu_if.master          mem,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] retire_pc,
    output logic [DATA_W-1:0] write_data
);
    localparam int unsigned NREGS = 2 ** REG_AW;
    localparam int unsigned IR_W  = 32;

    localparam logic [IR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_CPU_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] cur_pc_n;
    logic [IR_W-1:0]   ir, ir_n;
    logic [DATA_W-1:0] a_q, a_n;
    logic [DATA_W-1:0] b_q, b_n;
    logic [DATA_W-1:0] imm_q, imm_n;
    logic [DATA_W-1:0] wd_n;
    logic              halted_n;
    logic              req_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] ea;
    logic              launch;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;

    logic [DATA_W-1:0] rf [NREGS];

    // Instruction fields
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs_i, rt_i, rd_i;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] j_tgt;
    logic              unused_shamt;

    assign op     = ir[31:26];
    assign funct  = ir[5:0];
    assign rs_i   = REG_AW'(ir[25:21]);
    assign rt_i   = REG_AW'(ir[20:16]);
    assign rd_i   = REG_AW'(ir[15:11]);
    assign br_off = ADDR_W'($signed({ir[15:0], 2'b00}));
    // pc already holds PC+4 here; upper bits above 28 come from it, and the
    // mask collapses to zero when ADDR_W <= 28 so the target just truncates.
    assign j_tgt  = (pc & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});
    assign unused_shamt = ^ir[10:6];

    // Next-state, datapath and bus control
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        cur_pc_n = retire_pc;
        ir_n     = ir;
        a_n      = a_q;
        b_n      = b_q;
        imm_n    = imm_q;
        wd_n     = write_data;
        halted_n = halted;
        req_n    = mem.req;
        we_n     = mem.we;
        addr_n   = mem.addr;
        wdata_n  = mem.wdata;
        ea       = a_q + imm_q;
        launch   = 1'b0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = '0;

        case (state)
            S_FETCH: begin
                if (!mem.req) begin
                    // First fetch after reset: request goes out next cycle
                    launch = 1'b1;
                end else if (mem.ack) begin
                    ir_n  = IR_W'(mem.rdata);
                    pc_n  = pc + ADDR_W'(4);
                    req_n = 1'b0;
                    if (IR_W'(mem.rdata) == HALT_WORD) begin
                        state_n  = S_HALT;
                        halted_n = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        state_n = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                a_n     = (rs_i == '0) ? '0 : rf[rs_i];
                b_n     = (rt_i == '0) ? '0 : rf[rt_i];
                imm_n   = DATA_W'($signed(ir[15:0]));
                state_n = S_EXEC;
            end

            S_EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        state_n = S_WB;
                        case (funct)
                            FN_ADD:  wd_n = a_q + b_q;
                            FN_SUB:  wd_n = a_q - b_q;
                            FN_AND:  wd_n = a_q & b_q;
                            FN_OR:   wd_n = a_q | b_q;
                            FN_SLT:  wd_n = DATA_W'($signed(a_q) < $signed(b_q));
                            default: begin
                                state_n = S_FETCH;
                                retire  = 1'b1;
                                launch  = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI: begin
                        wd_n    = a_q + imm_q;
                        state_n = S_WB;
                    end
                    OP_LUI: begin
                        wd_n    = DATA_W'({ir[15:0], 16'h0000});
                        state_n = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        req_n   = 1'b1;
                        we_n    = (op == OP_SW);
                        addr_n  = ADDR_W'(ea) & ~ADDR_W'(3);
                        if (op == OP_SW) begin
                            wdata_n = b_q;
                        end
                        state_n = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_n = pc + br_off;
                        end
                        state_n = S_FETCH;
                        retire  = 1'b1;
                        launch  = 1'b1;
                    end
`ifdef MC_CPU_BNE_EN
                    OP_BNE: begin
                        if (a_q != b_q) begin
                            pc_n = pc + br_off;
                        end
                        state_n = S_FETCH;
                        retire  = 1'b1;
                        launch  = 1'b1;
                    end
`endif
                    OP_J: begin
                        pc_n    = j_tgt;
                        state_n = S_FETCH;
                        retire  = 1'b1;
                        launch  = 1'b1;
                    end
                    default: begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                        launch  = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                if (mem.ack) begin
                    req_n = 1'b0;
                    we_n  = 1'b0;
                    if (mem.we) begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                        launch  = 1'b1;
                    end else begin
                        wd_n    = mem.rdata;
                        state_n = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = (op == OP_RTYPE) ? rd_i : rt_i;
                retire  = 1'b1;
                state_n = S_FETCH;
                launch  = 1'b1;
            end

            S_HALT: begin
                state_n = S_HALT;
            end

            default: begin
                state_n = S_FETCH;
            end
        endcase

        // Pre-issue the fetch so FETCH can complete in its first cycle
        if (launch) begin
            req_n    = 1'b1;
            we_n     = 1'b0;
            addr_n   = pc_n & ~ADDR_W'(3);
            cur_pc_n = pc_n;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            retire_pc  <= '0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            write_data <= '0;
            halted     <= 1'b0;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            retire_pc  <= cur_pc_n;
            ir         <= ir_n;
            a_q        <= a_n;
            b_q        <= b_n;
            imm_q      <= imm_n;
            write_data <= wd_n;
            halted     <= halted_n;
            mem.req    <= req_n;
            mem.we     <= we_n;
            mem.addr   <= addr_n;
            mem.wdata  <= wdata_n;
        end
    end

    // Register file: not cleared by reset, r0 never written
    always_ff @(posedge clk) begin
        if (!rst && rf_we && (rf_wa != '0)) begin
            rf[rf_wa] <= write_data;
        end
    end
endmodule
